rca_chunk_sequencer: RTL and testbench

Multi-cycle adder controller that computes WIDTH = 3*NCHUNK bit sums by time-multiplexing a single external 3-bit ripple-carry adder slice, one 3-bit chunk per cycle, LSB chunk first, carry registered between chunks. It sits between an operand producer and a result consumer, each using valid/ready handshakes. It owns the slice's inputs and samples the slice's combinational outputs.

---
 rtl/rca_chunk_sequencer.sv | 99 +++++++++
 tb/tb_rca_chunk_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_chunk_sequencer.sv
// Multi-cycle adder controller: drives an external 3-bit ripple-carry slice
// one chunk per cycle, LSB first, carrying between chunks in a register.
module rca_chunk_sequencer #(
  parameter int unsigned NCHUNK = 4,
  localparam int unsigned WIDTH = 3 * NCHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [2:0]       slice_a,
  output logic [2:0]       slice_b,
  output logic             slice_cin,
  input  logic [2:0]       slice_sum,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    base;
  logic             last;

  // Bit offset of the chunk currently being added
  assign base = IW'(cnt) * IW'(3);
  assign last = (cnt == CW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: 3] <= slice_sum;
          carry              <= slice_cout;
          if (last) begin
            cout_reg <= slice_cout;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slice is only driven while a chunk is in flight
  assign slice_a   = (state == RUN) ? a_reg[base +: 3] : 3'd0;
  assign slice_b   = (state == RUN) ? b_reg[base +: 3] : 3'd0;
  assign slice_cin = (state == RUN) ? carry : 1'b0;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

endmodule

// File: tb/tb_rca_chunk_sequencer.sv
// Bench for rca_chunk_sequencer: ideal 3-bit slice, timeline/arithmetic model
// compared every cycle, directed literal cases, random traffic, NCHUNK=1 build.
module tb_rca_chunk_sequencer;

  localparam int N = 4;
  localparam int W = 3 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic         slice_cin, slice_cout;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [2:0]   slice_a, slice_b, slice_sum;

  logic       in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
  logic       slice_cin1, slice_cout1;
  logic [2:0] in_a1, in_b1, out_sum1, slice_a1, slice_b1, slice_sum1;

  // Ideal external adder slices
  assign {slice_cout, slice_sum}   = 4'(slice_a) + 4'(slice_b) + 4'(slice_cin);
  assign {slice_cout1, slice_sum1} = 4'(slice_a1) + 4'(slice_b1) + 4'(slice_cin1);

  rca_chunk_sequencer #(.NCHUNK(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .busy(busy)
  );

  rca_chunk_sequencer #(.NCHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .slice_a(slice_a1), .slice_b(slice_b1), .slice_cin(slice_cin1),
    .slice_sum(slice_sum1), .slice_cout(slice_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] low_mask(input int chunks);
    logic [W-1:0] r = '0;
    for (int i = 0; i < 3 * chunks && i < W; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Model: phase 0 idle, 1..N = chunk (phase-1) in flight, N+1 = result held
  bit           m_live = 1'b0;
  int           m_phase;
  logic [W-1:0] m_a, m_b, m_sum;
  logic         m_cin, m_cout;
  logic [W:0]   m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1'b1;
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else if (m_live) begin
      if (m_phase == 0) begin
        if (in_valid) begin
          m_a     <= in_a;
          m_b     <= in_b;
          m_cin   <= in_cin;
          m_res   <= (W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(in_cin);
          m_phase <= 1;
        end
      end else if (m_phase <= N) begin
        m_phase <= m_phase + 1;
      end else if (out_ready) begin
        m_sum   <= m_res[W-1:0];
        m_cout  <= m_res[W];
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin : cmp
      logic [W-1:0] mask, es;
      logic [W:0]   t;
      logic [2:0]   esa, esb;
      logic         escin, ecout;
      int           k;
      esa = 3'd0; esb = 3'd0; escin = 1'b0;
      es = m_sum; ecout = m_cout;
      if (m_phase >= 1 && m_phase <= N) begin
        k     = m_phase - 1;
        mask  = low_mask(k);
        es    = (m_res[W-1:0] & mask) | (m_sum & ~mask);
        esa   = 3'(m_a >> (3 * k));
        esb   = 3'(m_b >> (3 * k));
        t     = (W+1)'(m_a & mask) + (W+1)'(m_b & mask) + (W+1)'(m_cin);
        escin = t[3 * k];
      end else if (m_phase == N + 1) begin
        es    = m_res[W-1:0];
        ecout = m_res[W];
      end
      check("cyc_in_ready",  64'(in_ready),  64'(m_phase == 0));
      check("cyc_busy",      64'(busy),      64'(m_phase != 0));
      check("cyc_out_valid", 64'(out_valid), 64'(m_phase == N + 1));
      check("cyc_slice_a",   64'(slice_a),   64'(esa));
      check("cyc_slice_b",   64'(slice_b),   64'(esb));
      check("cyc_slice_cin", 64'(slice_cin), 64'(escin));
      check("cyc_out_sum",   64'(out_sum),   64'(es));
      check("cyc_out_cout",  64'(out_cout),  64'(ecout));
    end
  end

  logic [2:0] cap_a [16];
  logic       cap_cin [16];

  // Starts and ends on a negedge; returns edges from accept to out_valid
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int lat);
    check("op_in_ready", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat < 16) begin
        cap_a[lat]   = slice_a;
        cap_cin[lat] = slice_cin;
      end
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("fin_in_ready",  64'(in_ready),  64'd1);
    check("fin_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic         bc [3];
    int           acc [3];
    logic [W:0]   got [$];
    int           cyc, j;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_slice_a",   64'(slice_a),   64'd0);
    check("rst1_in_ready", 64'(in_ready1), 64'd1);

    // 0x123 + 0x456 + 1
    do_op(12'h123, 12'h456, 1'b1, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_sa0", 64'(cap_a[0]), 64'd3);
    check("t1_sa1", 64'(cap_a[1]), 64'd4);
    check("t1_sa2", 64'(cap_a[2]), 64'd4);
    check("t1_sa3", 64'(cap_a[3]), 64'd0);
    check("t1_sum",  64'(out_sum),  64'h57A);
    check("t1_cout", 64'(out_cout), 64'd0);
    finish_op();

    // 0xFFF + 0x001: carry through every chunk, then backpressure
    do_op(12'hFFF, 12'h001, 1'b0, lat);
    check("t2_latency", 64'(lat), 64'd4);
    check("t2_cin0", 64'(cap_cin[0]), 64'd0);
    check("t2_cin1", 64'(cap_cin[1]), 64'd1);
    check("t2_cin2", 64'(cap_cin[2]), 64'd1);
    check("t2_cin3", 64'(cap_cin[3]), 64'd1);
    check("t2_sum",  64'(out_sum),  64'h000);
    check("t2_cout", 64'(out_cout), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_sum",       64'(out_sum),   64'h000);
      check("bp_cout",      64'(out_cout),  64'd1);
    end
    in_valid = 1'b0;
    finish_op();

    // Reset during the second RUN cycle
    in_a = 12'h00A; in_b = 12'h005; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mr_in_ready",  64'(in_ready),  64'd1);
    check("mr_busy",      64'(busy),      64'd0);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_sum",   64'(out_sum),   64'd0);
    do_op(12'h00A, 12'h005, 1'b0, lat);
    check("mr_sum",  64'(out_sum),  64'h00F);
    check("mr_cout", 64'(out_cout), 64'd0);
    finish_op();

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      ba[i] = W'($urandom); bb[i] = W'($urandom); bc[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1; cyc = 0; j = 0;
    while ((j < 3 || got.size() < 3) && cyc < 200) begin
      if (out_valid) got.push_back({out_cout, out_sum});
      if (in_ready) begin
        if (j < 3) begin
          in_a = ba[j]; in_b = bb[j]; in_cin = bc[j]; in_valid = 1'b1;
          acc[j] = cyc; j++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); cyc++; @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", 64'(got.size()), 64'd3);
    check("b2b_gap01", 64'(acc[1] - acc[0]), 64'(N + 2));
    check("b2b_gap12", 64'(acc[2] - acc[1]), 64'(N + 2));
    for (int i = 0; i < 3 && i < got.size(); i++)
      check("b2b_result", 64'(got[i]),
            64'((W+1)'(ba[i]) + (W+1)'(bb[i]) + (W+1)'(bc[i])));

    // Random traffic with backpressure and occasional reset
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 3) begin @(posedge clk); @(negedge clk); end
    out_ready = 1'b0;
    check("rnd_idle", 64'(in_ready), 64'd1);

    // Single-chunk build: 7 + 7 + 1
    in_a1 = 3'd7; in_b1 = 3'd7; in_cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    check("n1_run_busy",  64'(busy1),      64'd1);
    check("n1_run_valid", 64'(out_valid1), 64'd0);
    check("n1_slice_a",   64'(slice_a1),   64'd7);
    check("n1_slice_cin", 64'(slice_cin1), 64'd1);
    @(posedge clk); @(negedge clk);
    check("n1_out_valid", 64'(out_valid1), 64'd1);
    check("n1_sum",       64'(out_sum1),   64'd7);
    check("n1_cout",      64'(out_cout1),  64'd1);
    check("n1_slice_idle", 64'(slice_a1),  64'd0);
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready1 = 1'b0;
    check("n1_in_ready",  64'(in_ready1),  64'd1);
    check("n1_done_clr",  64'(out_valid1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
